// File: rtl/qpsk_bit_splitter.sv
// Pairs a serial bit stream into QPSK symbols (even bit -> I, odd bit -> Q) and
// holds each symbol for SYM_LEN clocks, with gapless back-to-back symbols.
module qpsk_bit_splitter #(
  parameter int SYM_LEN    = 52,
  parameter int PAIR_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic bit_valid,
  output logic bit_ready,
  output logic i_bit,
  output logic q_bit,
  output logic sym_active,
  output logic sym_start,
  output logic underrun
);

  localparam int CNT_W  = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int PTR_W  = (PAIR_DEPTH > 1) ? $clog2(PAIR_DEPTH) : 1;
  localparam int FCNT_W = $clog2(PAIR_DEPTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SYM_LEN - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(PAIR_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              half_reg, half_i_reg;
  logic [1:0]        fifo_mem [PAIR_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [FCNT_W-1:0] count_reg;
  logic              i_reg, q_reg, start_reg, under_reg;
  logic              fifo_empty, fifo_full, accept, push, pop, underrun_next;
  logic [1:0]        head;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_CNT);
  // Only the pair-completing bit needs FIFO space, so a half bit is always taken.
  assign bit_ready  = !(fifo_full && half_reg);
  assign accept     = bit_valid && bit_ready;
  assign push       = accept && half_reg;
  assign head       = fifo_mem[rd_ptr_reg];

  assign i_bit      = i_reg;
  assign q_bit      = q_reg;
  assign sym_active = (state_reg == RUN);
  assign sym_start  = start_reg;
  assign underrun   = under_reg;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    pop           = 1'b0;
    underrun_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next = '0;
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_next    = IDLE;
            underrun_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {half_i_reg, bit_in};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      half_reg   <= 1'b0;
      half_i_reg <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      i_reg      <= 1'b0;
      q_reg      <= 1'b0;
      start_reg  <= 1'b0;
      under_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      start_reg <= pop;
      under_reg <= underrun_next;
      if (accept) begin
        half_reg <= !half_reg;
        if (!half_reg) begin
          half_i_reg <= bit_in;
        end
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        i_reg      <= head[1];
        q_reg      <= head[0];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_qpsk_bit_splitter.sv
// Directed bench for qpsk_bit_splitter: default 52-clock instance plus a
// SYM_LEN=4 instance, with event queues recorded on the falling edge.
module tb_qpsk_bit_splitter;

  logic clk;
  logic reset;
  logic bit_in, bit_valid, bit_ready, i_bit, q_bit, sym_active, sym_start, underrun;
  logic s_bit_in, s_bit_valid, s_bit_ready, s_i_bit, s_q_bit, s_sym_active, s_sym_start, s_underrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int excl_viol = 0;
  int acc_q[$], start_q[$], iq_q[$], und_q[$];
  int s_acc_q[$], s_start_q[$], s_iq_q[$], s_und_q[$];

  qpsk_bit_splitter u_dut (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .i_bit      (i_bit),
    .q_bit      (q_bit),
    .sym_active (sym_active),
    .sym_start  (sym_start),
    .underrun   (underrun)
  );

  qpsk_bit_splitter #(.SYM_LEN(4), .PAIR_DEPTH(2)) u_short (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (s_bit_in),
    .bit_valid  (s_bit_valid),
    .bit_ready  (s_bit_ready),
    .i_bit      (s_i_bit),
    .q_bit      (s_q_bit),
    .sym_active (s_sym_active),
    .sym_start  (s_sym_start),
    .underrun   (s_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // cyc at the falling edge equals the index of the edge that just occurred.
  always @(negedge clk) begin
    if (bit_valid && bit_ready) acc_q.push_back(cyc + 1);
    if (sym_start) begin
      start_q.push_back(cyc);
      iq_q.push_back(int'({i_bit, q_bit}));
    end
    if (underrun) und_q.push_back(cyc);
    if (sym_start && underrun) excl_viol++;
    if (s_bit_valid && s_bit_ready) s_acc_q.push_back(cyc + 1);
    if (s_sym_start) begin
      s_start_q.push_back(cyc);
      s_iq_q.push_back(int'({s_i_bit, s_q_bit}));
    end
    if (s_underrun) s_und_q.push_back(cyc);
    if (s_sym_start && s_underrun) excl_viol++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    bit_in    = b;
    bit_valid = 1'b1;
    while (!bit_ready && n < 300) begin
      tick();
      n++;
    end
    check("ready_wait", int'(bit_ready), 1);
    tick();
    bit_valid = 1'b0;
    $display("tx bit=%0d accepted at edge %0d after %0d stall cycles", b, cyc, n);
  endtask

  task automatic clear_queues();
    acc_q.delete(); start_q.delete(); iq_q.delete(); und_q.delete();
  endtask

  initial begin
    reset = 1'b0;
    bit_in = 1'b0; bit_valid = 1'b0;
    s_bit_in = 1'b0; s_bit_valid = 1'b0;
    repeat (3) tick();

    // T1: reset values, single symbol then underrun
    check("rst_i", int'(i_bit), 0);
    check("rst_q", int'(q_bit), 0);
    check("rst_active", int'(sym_active), 0);
    check("rst_start", int'(sym_start), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_ready", int'(bit_ready), 1);
    reset = 1'b1;
    tick();
    send_bit(1'b1);
    send_bit(1'b0);
    check("t1_idle_at_push", int'(sym_active), 0);
    tick();
    check("t1_i", int'(i_bit), 1);
    check("t1_q", int'(q_bit), 0);
    check("t1_active", int'(sym_active), 1);
    check("t1_start", int'(sym_start), 1);
    tick();
    check("t1_start_pulse", int'(sym_start), 0);
    repeat (50) tick();
    check("t1_active_last", int'(sym_active), 1);
    check("t1_no_early_underrun", int'(underrun), 0);
    tick();
    check("t1_active_end", int'(sym_active), 0);
    check("t1_underrun", int'(underrun), 1);
    check("t1_i_hold", int'(i_bit), 1);
    tick();
    check("t1_underrun_pulse", int'(underrun), 0);
    repeat (3) tick();

    // T2: three gapless symbols 11,00,10
    clear_queues();
    send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0);
    repeat (170) tick();
    check("t2_nstart", start_q.size(), 3);
    check("t2_nund", und_q.size(), 1);
    if (start_q.size() == 3 && und_q.size() == 1 && acc_q.size() >= 2) begin
      check("t2_load_latency", start_q[0], acc_q[1] + 1);
      check("t2_gap1", start_q[1] - start_q[0], 52);
      check("t2_gap2", start_q[2] - start_q[1], 52);
      check("t2_iq0", iq_q[0], 3);
      check("t2_iq1", iq_q[1], 0);
      check("t2_iq2", iq_q[2], 2);
      check("t2_und", und_q[0] - start_q[2], 52);
    end

    // T3/T4: continuous stream of 8 bits; the 8th stalls until the boundary pop
    clear_queues();
    send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b0);
    repeat (220) tick();
    check("t3_nacc", acc_q.size(), 8);
    check("t3_nstart", start_q.size(), 4);
    check("t3_nund", und_q.size(), 1);
    if (acc_q.size() == 8 && start_q.size() == 4 && und_q.size() == 1) begin
      check("t3_burst", acc_q[6] - acc_q[0], 6);
      check("t3_load", start_q[0], acc_q[1] + 1);
      check("t4_stall_accept", acc_q[7], start_q[0] + 53);
      check("t3_gap1", start_q[1] - start_q[0], 52);
      check("t3_gap2", start_q[2] - start_q[1], 52);
      check("t3_gap3", start_q[3] - start_q[2], 52);
      check("t3_iq0", iq_q[0], 2);
      check("t3_iq1", iq_q[1], 1);
      check("t3_iq2", iq_q[2], 3);
      check("t3_iq3", iq_q[3], 0);
      check("t3_und", und_q[0] - start_q[3], 52);
    end

    // T5: asynchronous reset mid-symbol with a half pair pending
    send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1);
    repeat (20) tick();
    check("t5_pre_i", int'(i_bit), 1);
    check("t5_pre_active", int'(sym_active), 1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_i", int'(i_bit), 0);
    check("t5_async_q", int'(q_bit), 0);
    check("t5_async_active", int'(sym_active), 0);
    check("t5_async_start", int'(sym_start), 0);
    check("t5_async_underrun", int'(underrun), 0);
    check("t5_async_ready", int'(bit_ready), 1);
    tick(); tick();
    reset = 1'b1;
    tick();
    send_bit(1'b0);
    send_bit(1'b1);
    tick();
    check("t5_i", int'(i_bit), 0);
    check("t5_q", int'(q_bit), 1);
    check("t5_active", int'(sym_active), 1);
    repeat (60) tick();

    // T6: SYM_LEN=4 instance
    s_bit_valid = 1'b1;
    s_bit_in = 1'b1; tick();
    s_bit_in = 1'b1; tick();
    s_bit_in = 1'b0; tick();
    s_bit_in = 1'b1; tick();
    s_bit_valid = 1'b0;
    $display("tx short-instance bits 1,1,0,1 driven ending at edge %0d", cyc);
    repeat (20) tick();
    check("t6_nacc", s_acc_q.size(), 4);
    check("t6_nstart", s_start_q.size(), 2);
    check("t6_nund", s_und_q.size(), 1);
    if (s_acc_q.size() == 4 && s_start_q.size() == 2 && s_und_q.size() == 1) begin
      check("t6_load", s_start_q[0], s_acc_q[1] + 1);
      check("t6_gap", s_start_q[1] - s_start_q[0], 4);
      check("t6_iq0", s_iq_q[0], 3);
      check("t6_iq1", s_iq_q[1], 1);
      check("t6_und", s_und_q[0] - s_start_q[1], 4);
    end

    check("start_underrun_exclusive", excl_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
